// File: rtl/planificador_divisor.sv
// planificador_divisor
// A shared base prescaler divides clk_in down to a base tick. Three channel
// dividers count base ticks. Each channel emits a one-cycle enable pulse and
// a square wave. A small handshake FSM rewrites one channel divisor at a time.
// Optional build macro: PLANIFICADOR_SYNC_LOAD_EN.
//   Defined:   divisor loads wait for the next base tick (IDLE -> WAIT_SYNC -> APPLY).
//   Undefined: loads land one cycle after the handshake (IDLE -> APPLY).
module planificador_divisor #(
    parameter int unsigned CLK_IN_FREQ = 50_000_000,
    parameter int unsigned BASE_FREQ   = 1_000_000,
    parameter logic [15:0] DEF_DIV     = 16'd1000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_ch,
    input  logic [15:0] cfg_div,
    output logic [2:0]  tick_out,
    output logic [2:0]  clk_out,
    output logic        err_out
);

    localparam int unsigned BASE_MAX = CLK_IN_FREQ / BASE_FREQ;
    localparam int unsigned BASE_W   = (BASE_MAX > 2) ? $clog2(BASE_MAX) : 1;
    localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(BASE_MAX - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        APPLY     = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         cap_ch_reg, cap_ch_next;
    logic [15:0]        cap_div_reg, cap_div_next;
    logic [BASE_W-1:0]  base_cnt_reg;
    logic               base_tick;
    logic               apply_en;
    logic               err_reg;

    // The base tick fires on the last count of the prescaler, and only while it runs.
    assign base_tick = enable && (base_cnt_reg == BASE_LAST);

    // Base prescaler: free-running 0..BASE_MAX-1 while enabled, frozen otherwise.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            base_cnt_reg <= '0;
        end else if (enable) begin
            if (base_cnt_reg == BASE_LAST) begin
                base_cnt_reg <= '0;
            end else begin
                base_cnt_reg <= base_cnt_reg + BASE_W'(1);
            end
        end
    end

    // Config FSM state and captured request. A reset drops any pending request.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cap_ch_reg  <= 2'd0;
            cap_div_reg <= 16'd0;
        end else begin
            state_reg   <= state_next;
            cap_ch_reg  <= cap_ch_next;
            cap_div_reg <= cap_div_next;
        end
    end

    // Config FSM next state: accept in IDLE, optionally align to a base tick, apply for one cycle.
    always_comb begin
        state_next   = state_reg;
        cap_ch_next  = cap_ch_reg;
        cap_div_next = cap_div_reg;
        cfg_ready    = 1'b0;
        apply_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    cap_ch_next  = cfg_ch;
                    cap_div_next = cfg_div;
`ifdef PLANIFICADOR_SYNC_LOAD_EN
                    state_next   = WAIT_SYNC;
`else
                    state_next   = APPLY;
`endif
                end
            end
            WAIT_SYNC: begin
                // A stopped prescaler would never tick, so do not wait for one.
                if (base_tick || !enable) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                apply_en   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sticky error: a request aimed at the nonexistent channel 3 reached APPLY.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (apply_en && (cap_ch_reg == 2'd3)) begin
            err_reg <= 1'b1;
        end
    end

    assign err_out = err_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            localparam logic [1:0] CH = 2'(gi);

            logic [15:0] div_reg;
            logic [15:0] cnt_reg;
            logic        tick_reg;
            logic        clk_reg;
            logic        hit;

            assign hit = apply_en && (cap_ch_reg == CH);

            // Channel divider: a load to this channel overrides any count update
            // in the same cycle. div=0 parks the channel with everything at 0.
            always_ff @(posedge clk_in or negedge rst_n) begin
                if (!rst_n) begin
                    div_reg  <= DEF_DIV;
                    cnt_reg  <= 16'd0;
                    tick_reg <= 1'b0;
                    clk_reg  <= 1'b0;
                end else begin
                    tick_reg <= 1'b0;
                    if (hit) begin
                        div_reg <= cap_div_reg;
                        cnt_reg <= 16'd0;
                        clk_reg <= 1'b0;
                    end else if (base_tick && (div_reg != 16'd0)) begin
                        if (cnt_reg == div_reg - 16'd1) begin
                            cnt_reg  <= 16'd0;
                            tick_reg <= 1'b1;
                            clk_reg  <= ~clk_reg;
                        end else begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                    end
                end
            end

            assign tick_out[gi] = tick_reg;
            assign clk_out[gi]  = clk_reg;
        end
    endgenerate

endmodule

// File: doc/planificador_divisor.md
PLANIFICADOR_DIVISOR -- requirements
Module: planificador_divisor

Interface
REQ-001 SHALL have parameter CLK_IN_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BASE_FREQ, default 1_000_000, shared base tick frequency in Hz; BASE_MAX = CLK_IN_FREQ/BASE_FREQ, at least 2.
REQ-003 SHALL have parameter DEF_DIV, default 16'd1000, per-channel divisor loaded at reset.
REQ-004 SHALL have port clk_in, input, 1, sole system clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1, high = base prescaler runs.
REQ-007 SHALL have port cfg_valid, input, 1, configuration request.
REQ-008 SHALL have port cfg_ready, output, 1, configuration request can be accepted.
REQ-009 SHALL have port cfg_ch, input, 2, target channel 0..2; 3 is invalid.
REQ-010 SHALL have port cfg_div, input, 16, new channel divisor in base ticks; 0 = channel off.
REQ-011 SHALL have port tick_out, output, 3, per-channel one-cycle enable pulse.
REQ-012 SHALL have port clk_out, output, 3, per-channel square wave, toggles on each channel tick.
REQ-013 SHALL have port err_out, output, 1, sticky flag for an invalid cfg_ch.

Function
REQ-014 Base counter SHALL count 0..BASE_MAX-1 while enable=1; base_tick is high in the cycle where count=BASE_MAX-1, then count wraps to 0.
REQ-015 While enable=0, the base counter, channel counters, tick_out and clk_out SHALL hold (tick_out=0), and no base_tick SHALL occur.
REQ-016 On base_tick, each channel with div≠0 SHALL increment its 16-bit counter; when counter=div-1 it SHALL wrap to 0, pulse tick_out[ch] high for exactly the next clk_in cycle (registered, latency 1) and toggle clk_out[ch].
REQ-017 A channel with div=0 SHALL hold its counter at 0, tick_out[ch]=0 and clk_out[ch]=0; div=1 SHALL tick on every base_tick.
REQ-018 Config FSM states SHALL be IDLE, WAIT_SYNC and APPLY; cfg_ready=1 only in IDLE.
REQ-019 IDLE: on cfg_valid&cfg_ready, cfg_ch and cfg_div SHALL be captured and the FSM SHALL go to WAIT_SYNC (or to APPLY, see REQ-027).
REQ-020 WAIT_SYNC SHALL move to APPLY in the cycle after base_tick; it SHALL move immediately if enable=0.
REQ-021 APPLY (one cycle) SHALL load div[ch], clear the counter of ch and clear clk_out[ch], then return to IDLE; other channels SHALL be unaffected.
REQ-022 If a channel counter update and APPLY hit the same channel in the same cycle, APPLY SHALL win and no tick SHALL be issued.
REQ-023 A request with cfg_ch=3 SHALL be accepted and run the FSM, SHALL change no divisor, and SHALL set err_out=1 until reset.
REQ-024 cfg_valid while cfg_ready=0 SHALL be ignored; the requester holds it until accepted.

Reset
REQ-025 While rst_n=0, regardless of clk_in: base counter=0, channel counters=0, div[0..2]=DEF_DIV, FSM=IDLE, cfg_ready=1 on the first clock after release, tick_out=0, clk_out=0, err_out=0.
REQ-026 Reset asserted mid-transaction SHALL discard the captured request; no partial load.

Configuration
REQ-027 Macro PLANIFICADOR_SYNC_LOAD_EN: when defined, loads SHALL be aligned to base_tick per REQ-020; when undefined, IDLE SHALL go straight to APPLY on acceptance (WAIT_SYNC unused) and the load lands 1 cycle after the handshake.

Verification
Use CLK_IN_FREQ=100, BASE_FREQ=10 (BASE_MAX=10) and DEF_DIV=4.
REQ-028 Reset release, enable=1 -> base_tick every 10 cycles; tick_out[0..2] every 40 cycles; clk_out has an 80-cycle period.
REQ-029 Write ch1 div=2 mid base period with SYNC_LOAD_EN -> cfg_ready low until the APPLY cycle right after the next base_tick; then tick_out[1] every 20 cycles; ch0 and ch2 keep 40-cycle spacing.
REQ-030 Write ch2 div=0 -> tick_out[2] and clk_out[2] stay 0; rewrite div=1 -> tick_out[2] every 10 cycles.
REQ-031 Write cfg_ch=3 div=5 -> err_out=1 and stays set; all channels keep 40-cycle spacing; a later rst_n pulse clears err_out.
REQ-032 enable=0 for 25 cycles, then rst_n pulse during WAIT_SYNC -> no ticks while disabled; after reset all div=4 and the pending write is lost.
